// File: rtl/seq_code_pkg.sv
// Symbol constants and state encoding for the unlock-code generator.
// The pattern-detector FSM imports the same symbol constants.
package seq_code_pkg;

   localparam logic [1:0] SYM_IDLE = 2'b00;
   localparam logic [1:0] SYM_A    = 2'b10;
   localparam logic [1:0] SYM_B    = 2'b11;
   localparam logic [1:0] SYM_C    = 2'b10;
   localparam logic [1:0] SYM_D    = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYM0 = 3'd1,
      ST_SYM1 = 3'd2,
      ST_SYM2 = 3'd3,
      ST_SYM3 = 3'd4
   } seq_state_t;

   function automatic logic [1:0] sym_of(input seq_state_t st);
      case (st)
         ST_SYM0: return SYM_A;
         ST_SYM1: return SYM_B;
         ST_SYM2: return SYM_C;
         ST_SYM3: return SYM_D;
         default: return SYM_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/code_sequence_generator_hold_counter.sv
// Symbol hold counter: counts up while enabled, clears on request,
// flags when the count equals the supplied terminal value.
module hold_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] terminal,
   output logic             tc
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == terminal);

endmodule

// File: rtl/code_sequence_generator.sv
// Emits the unlock code 10 -> 11 -> 10 -> 01, each symbol held HOLD_CYCLES
// (the last one HOLD_CYCLES+TAIL_CYCLES), with a start/busy/done handshake.
module code_sequence_generator
   import seq_code_pkg::*;
#(
   parameter int HOLD_CYCLES = 3,
   parameter int TAIL_CYCLES = 2,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   output logic [1:0] sym_out,
   output logic       busy,
   output logic       done,
   output logic [1:0] step,
   output seq_state_t state_dbg
);

   // Handshake: start is taken only in IDLE with abort low; busy stays high for
   // the whole sequence; done pulses for one cycle after a normal finish only.
   // A start seen during that done cycle begins the next sequence immediately.

   if (HOLD_CYCLES == 0 ||
       longint'(HOLD_CYCLES + TAIL_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_param_error
      $error("code_sequence_generator: HOLD_CYCLES/TAIL_CYCLES do not fit CNT_W");
   end

   localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_TC = CNT_W'(HOLD_CYCLES + TAIL_CYCLES - 1);

   seq_state_t       state;
   seq_state_t       next_sym_state;
   logic [CNT_W-1:0] terminal;
   logic             cnt_clear;
   logic             tc;

   assign terminal       = (state == ST_SYM3) ? LAST_TC : HOLD_TC;
   assign next_sym_state = seq_state_t'(state + 3'd1);
   // The counter restarts on every state change, so it never wraps.
   assign cnt_clear      = (state == ST_IDLE) || abort || tc;
   assign state_dbg      = state;

   hold_counter #(
      .CNT_W(CNT_W)
   ) u_hold (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .enable   (1'b1),
      .terminal (terminal),
      .tc       (tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         sym_out <= SYM_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         step    <= 2'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  state   <= ST_SYM0;
                  sym_out <= SYM_A;
                  busy    <= 1'b1;
                  step    <= 2'd0;
               end
            end
            default: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  sym_out <= SYM_IDLE;
                  busy    <= 1'b0;
                  step    <= 2'd0;
               end else if (tc) begin
                  if (state == ST_SYM3) begin
                     state   <= ST_IDLE;
                     sym_out <= SYM_IDLE;
                     busy    <= 1'b0;
                     step    <= 2'd0;
                     done    <= 1'b1;
                  end else begin
                     state   <= next_sym_state;
                     sym_out <= sym_of(next_sym_state);
                     step    <= step + 2'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule
